// File: rtl/pixel_pack_writer_if.sv
// Pixel-in / BRAM-write-out bundle between the core's output stage and bram_ctrl.
// Contains the start/end control, the pixel stream with its stall, and the write port.
// master: upstream/controller side. slave: the packer itself.
interface pixel_pack_writer_if #(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CHANNEL = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32
);
    // frame control
    logic                              i_start;
    logic [ADDR_WIDTH-1:0]             i_base_addr;
    logic                              i_end;
    // pixel stream
    logic [BIT_WIDTH*NUM_CHANNEL-1:0]  idat;
    logic                              ival;
    logic                              ostall;
    // BRAM write port
    logic                              i_wstall;
    logic [ADDR_WIDTH-1:0]             o_wadd;
    logic                              o_wren;
    logic [DATA_WIDTH-1:0]             o_idat;
    logic [DATA_WIDTH/BIT_WIDTH-1:0]   o_wbe;
    // status
    logic [ADDR_WIDTH-1:0]             o_wcnt;
    logic                              o_done;
    logic                              o_err;

    modport master (
        output i_start, i_base_addr, i_end, idat, ival, i_wstall,
        input  ostall, o_wadd, o_wren, o_idat, o_wbe, o_wcnt, o_done, o_err
    );

    modport slave (
        input  i_start, i_base_addr, i_end, idat, ival, i_wstall,
        output ostall, o_wadd, o_wren, o_idat, o_wbe, o_wcnt, o_done, o_err
    );
endinterface

// File: rtl/pixel_pack_writer.sv
// Packs NUM_CHANNEL-sample pixels densely into DATA_WIDTH BRAM words with sequential addresses.
// Latency: word completed at edge k is written (o_wren high) in the cycle after edge k+1.
// Backpressure: ostall while the byte buffer cannot take a whole pixel, and in IDLE/FLUSH;
//   i_wstall holds writes, letting the buffer fill until ostall rises.
// Ports: clk/rst plain; everything else through pixel_pack_writer_if.slave (bus).
module pixel_pack_writer #(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CHANNEL = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int ADDR_INC    = 1,
    parameter int BUF_BYTES   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_pack_writer_if.slave   bus
);
    localparam int BPP  = NUM_CHANNEL;
    localparam int BPW  = DATA_WIDTH / BIT_WIDTH;
    localparam int CW   = $clog2(BUF_BYTES + 1);
    localparam int BUFW = BUF_BYTES * BIT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state, state_nxt;

    // byte buffer: byte 0 (lowest lane) is always the oldest byte
    logic [BUFW-1:0]        byte_buf, buf_nxt, buf_shift;
    logic [CW-1:0]          cnt, cnt_nxt, cnt_base;

    logic [ADDR_WIDTH-1:0]  addr;
    logic [ADDR_WIDTH-1:0]  wadd_q;
    logic                   wren_q;
    logic [DATA_WIDTH-1:0]  wdat_q;
    logic [BPW-1:0]         wbe_q;
    logic [ADDR_WIDTH-1:0]  wcnt_q;
    logic                   err_q;

    logic                   stall;
    logic                   push;
    logic                   pop_full;
    logic                   pop_part;
    logic                   done;
    logic                   err_set;

    logic [BPW-1:0]         part_wbe;
    logic [DATA_WIDTH-1:0]  part_mask;

    // ------------------------------------------------------------------
    // state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // next state and per-cycle actions
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        push      = 1'b0;
        pop_full  = 1'b0;
        pop_part  = 1'b0;
        done      = 1'b0;

        case (state)
            S_IDLE: begin
                stall = 1'b1;
                if (bus.i_start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                stall    = (cnt > CW'(BUF_BYTES - BPP));
                push     = bus.ival && !stall;
                pop_full = (cnt >= CW'(BPW)) && !bus.i_wstall;
                // a pixel arriving with i_end is still taken by push above
                if (bus.i_end) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                stall    = 1'b1;
                pop_full = (cnt >= CW'(BPW)) && !bus.i_wstall;
                pop_part = (cnt != '0) && (cnt < CW'(BPW)) && !bus.i_wstall;
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // restart overrides everything: no data moves on the restart edge
        if (bus.i_start) begin
            state_nxt = S_RUN;
            push      = 1'b0;
            pop_full  = 1'b0;
            pop_part  = 1'b0;
        end
    end

    // a pixel is dropped and flagged if offered while stalled or outside RUN
    assign err_set = bus.ival && (stall || (state != S_RUN));

    // ------------------------------------------------------------------
    // buffer update: pop first (shift down), then append at the new tail
    // ------------------------------------------------------------------
    always_comb begin
        buf_shift = byte_buf;
        cnt_base  = cnt;
        if (pop_full) begin
            buf_shift = byte_buf >> DATA_WIDTH;
            cnt_base  = cnt - CW'(BPW);
        end

        buf_nxt = buf_shift;
        cnt_nxt = cnt_base;

        if (pop_part) begin
            buf_nxt = '0;
            cnt_nxt = '0;
        end

        if (push) begin
            for (int p = 0; p < BUF_BYTES; p++) begin
                for (int j = 0; j < BPP; j++) begin
                    if (p == int'(cnt_base) + j) begin
                        buf_nxt[p*BIT_WIDTH +: BIT_WIDTH] = bus.idat[j*BIT_WIDTH +: BIT_WIDTH];
                    end
                end
            end
            cnt_nxt = cnt_base + CW'(BPP);
        end
    end

    // byte enables and data mask for the zero-padded final word
    always_comb begin
        part_wbe  = '0;
        part_mask = '0;
        for (int i = 0; i < BPW; i++) begin
            if (i < int'(cnt)) begin
                part_wbe[i]                         = 1'b1;
                part_mask[i*BIT_WIDTH +: BIT_WIDTH] = '1;
            end
        end
    end

    // ------------------------------------------------------------------
    // datapath and write-port registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_buf <= '0;
            cnt      <= '0;
            addr     <= '0;
            wadd_q   <= '0;
            wren_q   <= 1'b0;
            wdat_q   <= '0;
            wbe_q    <= '0;
            wcnt_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            if (bus.i_start) begin
                byte_buf <= '0;
                cnt      <= '0;
                addr     <= bus.i_base_addr;
                wcnt_q   <= '0;
                err_q    <= 1'b0;
            end else begin
                byte_buf <= buf_nxt;
                cnt      <= cnt_nxt;
                if (err_set) begin
                    err_q <= 1'b1;
                end
                if (pop_full || pop_part) begin
                    wren_q <= 1'b1;
                    wadd_q <= addr;
                    addr   <= addr + ADDR_WIDTH'(ADDR_INC);
                    wcnt_q <= wcnt_q + 1'b1;
                    if (pop_full) begin
                        wdat_q <= byte_buf[DATA_WIDTH-1:0];
                        wbe_q  <= '1;
                    end else begin
                        wdat_q <= byte_buf[DATA_WIDTH-1:0] & part_mask;
                        wbe_q  <= part_wbe;
                    end
                end
            end
        end
    end

    assign bus.ostall = stall;
    assign bus.o_wadd = wadd_q;
    assign bus.o_wren = wren_q;
    assign bus.o_idat = wdat_q;
    assign bus.o_wbe  = wbe_q;
    assign bus.o_wcnt = wcnt_q;
    assign bus.o_done = done;
    assign bus.o_err  = err_q;

endmodule

// File: tb/tb_pixel_pack_writer.sv
// Bench for pixel_pack_writer: byte-stream model feeds an expected-write queue,
// a negedge monitor pops and compares every o_wren beat.
module tb_pixel_pack_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_pack_writer_if #(.BIT_WIDTH(8), .NUM_CHANNEL(3), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    pixel_pack_writer #(
        .BIT_WIDTH(8), .NUM_CHANNEL(3), .DATA_WIDTH(32),
        .ADDR_WIDTH(32), .ADDR_INC(1), .BUF_BYTES(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wbe;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] byte_q[$];
    logic [31:0] m_addr;
    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // write-port monitor
    always @(negedge clk) begin
        wr_t e;
        if (bus.o_wren === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(bus.o_wadd), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("wadd", 64'(bus.o_wadd), 64'(e.addr));
                check("wdata", 64'(bus.o_idat), 64'(e.data));
                check("wbe", 64'(bus.o_wbe), 64'(e.wbe));
            end
        end
        if (bus.o_done === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_words();
        wr_t w;
        while (byte_q.size() >= 4) begin
            w.addr = m_addr;
            w.wbe  = 4'hF;
            w.data = '0;
            for (int i = 0; i < 4; i++) w.data[8*i +: 8] = byte_q.pop_front();
            exp_q.push_back(w);
            m_addr = m_addr + 32'd1;
        end
    endfunction

    function automatic void model_flush();
        wr_t w;
        model_words();
        if (byte_q.size() > 0) begin
            w.addr = m_addr;
            w.data = '0;
            w.wbe  = '0;
            for (int i = 0; i < 4; i++) begin
                if (byte_q.size() > 0) begin
                    w.data[8*i +: 8] = byte_q.pop_front();
                    w.wbe[i] = 1'b1;
                end
            end
            exp_q.push_back(w);
            m_addr = m_addr + 32'd1;
        end
    endfunction

    task automatic start(input logic [31:0] base);
        bus.i_start     = 1'b1;
        bus.i_base_addr = base;
        step();
        bus.i_start = 1'b0;
        byte_q.delete();
        m_addr = base;
    endtask

    // waits for ostall low, then presents one pixel for exactly one edge
    task automatic send_pixel(input logic [23:0] p);
        int t = 0;
        bus.ival = 1'b0;
        while (bus.ostall && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) check("ostall_timeout", 64'(t), 64'd0);
        bus.ival = 1'b1;
        bus.idat = p;
        for (int j = 0; j < 3; j++) byte_q.push_back(p[8*j +: 8]);
        model_words();
        step();
        bus.ival = 1'b0;
    endtask

    task automatic end_frame();
        int snap = done_cnt;
        int t = 0;
        bus.i_end = 1'b1;
        step();
        bus.i_end = 1'b0;
        model_flush();
        while (done_cnt == snap && t < 200) begin
            step();
            t++;
        end
        step();
        check("done_pulse", 64'(done_cnt - snap), 64'd1);
        check("drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            step();
            t++;
        end
        step();
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wren"}, 64'(bus.o_wren), 64'd0);
        check({tag, "_wadd"}, 64'(bus.o_wadd), 64'd0);
        check({tag, "_idat"}, 64'(bus.o_idat), 64'd0);
        check({tag, "_wbe"},  64'(bus.o_wbe),  64'd0);
        check({tag, "_wcnt"}, 64'(bus.o_wcnt), 64'd0);
        check({tag, "_done"}, 64'(bus.o_done), 64'd0);
        check({tag, "_err"},  64'(bus.o_err),  64'd0);
    endtask

    initial begin
        int acc;
        int snap_wr;
        int snap_done;
        logic [23:0] pix [0:3];
        pix[0] = 24'h030201;
        pix[1] = 24'h060504;
        pix[2] = 24'h090807;
        pix[3] = 24'h0C0B0A;

        bus.i_start = 1'b0;
        bus.i_base_addr = '0;
        bus.i_end = 1'b0;
        bus.idat = '0;
        bus.ival = 1'b0;
        bus.i_wstall = 1'b0;
        m_addr = '0;

        // reset state
        repeat (3) step();
        check_outputs_zero("reset");
        check("reset_ostall_idle", 64'(bus.ostall), 64'd1);
        rst = 1'b0;
        step();

        // basic packing
        start(32'h100);
        for (int i = 0; i < 4; i++) send_pixel(pix[i]);
        end_frame();
        check("basic_wcnt", 64'(bus.o_wcnt), 64'd3);
        check("basic_err", 64'(bus.o_err), 64'd0);

        // partial flush
        start(32'h0);
        send_pixel(pix[0]);
        send_pixel(pix[1]);
        end_frame();
        check("partial_wcnt", 64'(bus.o_wcnt), 64'd2);

        // backpressure: writes held, buffer fills to 6 bytes
        start(32'h600);
        bus.i_wstall = 1'b1;
        snap_wr = wr_cnt;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            if (!bus.ostall && acc < 4) begin
                send_pixel(pix[acc]);
                acc++;
            end else begin
                step();
            end
        end
        check("bp_accepted", 64'(acc), 64'd2);
        check("bp_ostall", 64'(bus.ostall), 64'd1);
        check("bp_no_write", 64'(wr_cnt - snap_wr), 64'd0);
        bus.i_wstall = 1'b0;
        send_pixel(pix[2]);
        send_pixel(pix[3]);
        end_frame();
        check("bp_wcnt", 64'(bus.o_wcnt), 64'd3);

        // overflow: drive a pixel while stalled
        start(32'h700);
        bus.i_wstall = 1'b1;
        send_pixel(24'h232221);
        send_pixel(24'h262524);
        check("ovf_ostall", 64'(bus.ostall), 64'd1);
        bus.ival = 1'b1;
        bus.idat = 24'hEEEEEE;
        step();
        bus.ival = 1'b0;
        check("ovf_err_set", 64'(bus.o_err), 64'd1);
        bus.i_wstall = 1'b0;
        send_pixel(24'h292827);
        send_pixel(24'h2C2B2A);
        end_frame();
        check("ovf_err_sticky", 64'(bus.o_err), 64'd1);
        start(32'h0);
        check("ovf_err_cleared", 64'(bus.o_err), 64'd0);
        end_frame();

        // reset mid-frame with 2 bytes buffered
        start(32'h400);
        send_pixel(24'h333231);
        send_pixel(24'h363534);
        wait_drain();
        snap_wr = wr_cnt;
        snap_done = done_cnt;
        rst = 1'b1;
        #2;
        check_outputs_zero("midrst");
        byte_q.delete();
        step();
        rst = 1'b0;
        repeat (10) step();
        check("midrst_no_write", 64'(wr_cnt - snap_wr), 64'd0);
        check("midrst_no_done", 64'(done_cnt - snap_done), 64'd0);

        // restart mid-frame with 2 bytes buffered
        start(32'h500);
        send_pixel(24'h434241);
        send_pixel(24'h464544);
        wait_drain();
        snap_done = done_cnt;
        start(32'h200);
        check("restart_wcnt_clr", 64'(bus.o_wcnt), 64'd0);
        send_pixel(24'h131211);
        send_pixel(24'h161514);
        end_frame();
        check("restart_single_done", 64'(done_cnt - snap_done), 64'd1);

        // address wrap
        start(32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) send_pixel(24'h505050 + 24'(i * 24'h030303));
        end_frame();
        check("wrap_wcnt", 64'(bus.o_wcnt), 64'd6);
        check("wrap_last_addr", 64'(bus.o_wadd), 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pixel_pack_writer.md
Name: pixel_pack_writer

Overview:
- Write-side counterpart of pixel_concat and data_req. pixel_concat/data_req read 32-bit BRAM words and split them into NUM_CHANNEL-byte pixels; this block does the reverse.
- Accepts a stream of NUM_CHANNEL×BIT_WIDTH pixels, repacks the bytes densely into DATA_WIDTH words, and generates sequential write address, write enable and byte enables toward a bram_ctrl write port.
- Sits between the core's output stage and the output BRAM controller. Provides backpressure upstream and a flush/done handshake at end of frame.

Parameters:
- BIT_WIDTH, 8, bits per channel sample.
- NUM_CHANNEL, 3, samples per input pixel.
- DATA_WIDTH, 32, BRAM word width; must be a multiple of BIT_WIDTH.
- ADDR_WIDTH, 32, write address width.
- ADDR_INC, 1, address increment per word written.
- BUF_BYTES, 8, byte-buffer capacity (≥ 2×DATA_WIDTH/BIT_WIDTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_start  in  1  pulse: load base address, clear buffer, enter RUN
- i_base_addr  in  ADDR_WIDTH  first word address, sampled on i_start
- idat  in  BIT_WIDTH*NUM_CHANNEL  pixel; idat[BIT_WIDTH-1:0] is channel 0, written first
- ival  in  1  idat valid
- ostall  out  1  upstream must not assert ival while high
- i_end  in  1  pulse: no more pixels, flush buffer
- i_wstall  in  1  downstream hold; no write issued while high
- o_wadd  out  ADDR_WIDTH  write address
- o_wren  out  1  write strobe, one cycle per word
- o_idat  out  DATA_WIDTH  write data
- o_wbe  out  DATA_WIDTH/BIT_WIDTH  byte enables
- o_wcnt  out  ADDR_WIDTH  words written since i_start
- o_done  out  1  one-cycle pulse after the final flush write
- o_err  out  1  sticky overflow flag (ival while ostall, or ival outside RUN)

Behaviour:
- Reset: all outputs 0, buffer count 0, state IDLE. Reset mid-operation discards buffered bytes and does not assert o_done.
- Terms: BPP = NUM_CHANNEL; BPW = DATA_WIDTH/BIT_WIDTH; cnt = registered buffer byte count.
- Byte order: bytes are little-endian in time. The oldest buffered byte goes to o_idat[BIT_WIDTH-1:0].
- ostall (combinational from registered state):
  - 1 in IDLE and FLUSH.
  - 1 in RUN when cnt > BUF_BYTES − BPP.
  - 0 otherwise.
- Push: in RUN, an ival without ostall appends BPP bytes.
- Pop: when cnt ≥ BPW and i_wstall = 0, the low BPW bytes are removed. On that edge the output registers are set:
  - o_idat = those bytes, o_wbe = all ones, o_wren = 1, o_wadd = current address;
  - address advances by ADDR_INC; o_wcnt increments.
- Push and pop in the same cycle are both applied: cnt_next = cnt + BPP − BPW.
- o_wren is deasserted on every cycle without a pop.
- Latency: if the byte completing a word is sampled at edge k, o_wren is high for the cycle following edge k+1.
- Address wraps modulo 2^ADDR_WIDTH.
- FSM:
  - IDLE → RUN on i_start.
  - RUN → FLUSH on i_end. If ival and i_end occur on the same edge, the pixel is accepted first.
  - FLUSH: drains full words as in RUN. When 0 < cnt < BPW and i_wstall = 0, it writes one zero-padded word with o_wbe bit i = (i < cnt), and cnt becomes 0.
  - FLUSH with cnt = 0 → DONE.
  - DONE: o_done = 1 for one cycle, then → IDLE.
- i_start in any non-IDLE state: immediate restart. Buffer is cleared, base address reloaded, o_wcnt cleared, no o_done, state → RUN.
- i_end in IDLE is ignored.
- o_err is set on any ival while ostall = 1, or on ival in a state other than RUN. The offending pixel is dropped. o_err clears only on rst or i_start.

Test Plan:
- Basic packing: rst, i_start with base 0x100, then 4 back-to-back pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A, then i_end. Required writes: 0x04030201 @0x100, 0x08070605 @0x101, 0x0C0B0A09 @0x102, all o_wbe = 0xF; o_wcnt = 3; o_done pulses once; o_err = 0.
- Partial flush: i_start base 0x0, pixels 0x030201 and 0x060504, then i_end. Required writes: 0x04030201 @0x0 wbe 0xF, then 0x00000605 @0x1 wbe 0x3, then o_done.
- Backpressure: hold i_wstall = 1 while pushing pixels every cycle the bench sees ostall = 0. ostall must rise when cnt = 6 and no pixel may be lost. Release i_wstall: words must drain in order, and the first word equals 0x04030201 for the sequence above.
- Overflow: force ival high while ostall = 1. o_err = 1 and stays set; the dropped pixel is absent from later writes; i_start clears o_err.
- Reset / restart mid-frame: with 2 bytes buffered, assert rst. All outputs are 0 and no write or done occurs. Repeat with i_start (base 0x200) instead of rst: the next write lands at 0x200 and contains only new bytes.
- Address wrap: base 0xFFFFFFFF, 8 pixels. Writes go to 0xFFFFFFFF, 0x0, 0x1, 0x2, 0x3, 0x4, and o_wcnt = 6.
